// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    // funct3 encodings of the M-extension operations
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    // Control FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // One radix-2 step per CALC cycle
    localparam int         CALC_CYCLES = 32;
    localparam logic [4:0] CNT_LAST    = 5'(CALC_CYCLES - 1);

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate: used both to take absolute values
// of operands and to re-apply the result sign.
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    // Negate when requested, otherwise pass through
    assign o_val = i_neg ? (-i_val) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes
// on accept, 32 unsigned radix-2 steps run in CALC, and the sign is
// restored on the edge that enters DONE. Divide-by-zero and signed
// overflow bypass CALC and go straight to DONE.
//
// Handshake: start is taken only while in IDLE (busy low); while busy is
// high, start is ignored and the requester must hold the instruction.
// The result is presented for exactly one cycle with done high; rd_addr
// and rd_data stay stable until the next accept.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr_in,
    output logic            busy,
    output logic            done,
    output logic            write_enable,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    output state_t          dbg_state
);

    // ---------------- registers ----------------
    state_t              r_state;
    logic [4:0]          r_cnt;
    logic [2:0]          r_op;
    logic                r_res_neg;
    logic [2*XLEN-1:0]   r_acc;     // multiply: {partial product, multiplier}
    logic [XLEN-1:0]     r_opb;     // multiplicand or divisor magnitude
    logic [XLEN-1:0]     r_quot;    // dividend shifting out, quotient shifting in
    logic [XLEN-1:0]     r_rem;     // partial remainder
    logic                r_busy;
    logic                r_done;
    logic                r_we;
    logic [4:0]          r_rd_addr;
    logic [XLEN-1:0]     r_rd_data;

    // ---------------- operand conditioning ----------------
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_neg_a;
    logic            w_neg_b;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_res_neg;
    logic [XLEN-1:0] w_special;

    assign w_a_signed = (op == OP_MULH) || (op == OP_MULHSU) ||
                        (op == OP_DIV)  || (op == OP_REM);
    assign w_b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign w_neg_a    = w_a_signed & rs1_data[XLEN-1];
    assign w_neg_b    = w_b_signed & rs2_data[XLEN-1];

    // Remainder follows the dividend; product and quotient follow the XOR
    assign w_res_neg  = (op == OP_REM) ? w_neg_a : (w_neg_a ^ w_neg_b);

    assign w_div_zero = op[2] && (rs2_data == '0);
    assign w_ovf      = ((op == OP_DIV) || (op == OP_REM)) &&
                        (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                        (rs2_data == '1);

    muldiv_sign_fix #(.W(XLEN)) u_abs_a (
        .i_val (rs1_data),
        .i_neg (w_neg_a),
        .o_val (w_abs_a)
    );

    muldiv_sign_fix #(.W(XLEN)) u_abs_b (
        .i_val (rs2_data),
        .i_neg (w_neg_b),
        .o_val (w_abs_b)
    );

    // Fixed results for the cases that skip iteration (op[1] selects REM*)
    always_comb begin
        w_special = '0;
        if (w_div_zero) begin
            w_special = op[1] ? rs1_data : '1;
        end else begin
            w_special = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // ---------------- one iteration step ----------------
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_acc_next;
    logic [XLEN:0]       w_trial;
    logic [XLEN:0]       w_diff;
    logic [XLEN-1:0]     w_rem_next;
    logic [XLEN-1:0]     w_quot_next;
    logic [2*XLEN-1:0]   w_raw;
    logic [2*XLEN-1:0]   w_fixed;
    logic [XLEN-1:0]     w_final;

    // Shift-add: add multiplicand to the upper half when the multiplier LSB is set
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                        (r_acc[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
    assign w_acc_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Restoring divide: keep the difference only when it did not borrow
    assign w_trial     = {r_rem, r_quot[XLEN-1]};
    assign w_diff      = w_trial - {1'b0, r_opb};
    assign w_rem_next  = w_diff[XLEN] ? w_trial[XLEN-1:0] : w_diff[XLEN-1:0];
    assign w_quot_next = {r_quot[XLEN-2:0], ~w_diff[XLEN]};

    // Result before sign correction, using the final step's outputs
    always_comb begin
        w_raw = w_acc_next;
        if (r_op[2]) begin
            w_raw = r_op[1] ? {{XLEN{1'b0}}, w_rem_next} : {{XLEN{1'b0}}, w_quot_next};
        end
    end

    muldiv_sign_fix #(.W(2*XLEN)) u_res_fix (
        .i_val (w_raw),
        .i_neg (r_res_neg),
        .o_val (w_fixed)
    );

    // MUL and all divides use the low word; MULH* take the high word
    assign w_final = ((r_op == OP_MUL) || r_op[2]) ? w_fixed[XLEN-1:0]
                                                   : w_fixed[2*XLEN-1:XLEN];

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 5'd0;
            r_op      <= OP_MUL;
            r_res_neg <= 1'b0;
            r_acc     <= '0;
            r_opb     <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_we      <= 1'b0;
            r_rd_addr <= 5'd0;
            r_rd_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_we   <= 1'b0;
                    if (start) begin
                        r_op      <= op;
                        r_rd_addr <= rd_addr_in;
                        r_cnt     <= 5'd0;
                        r_busy    <= 1'b1;
                        r_res_neg <= w_res_neg;
                        r_acc     <= {{XLEN{1'b0}}, w_abs_b};
                        r_opb     <= op[2] ? w_abs_b : w_abs_a;
                        r_quot    <= w_abs_a;
                        r_rem     <= '0;
                        if (w_div_zero || w_ovf) begin
                            r_rd_data <= w_special;
                            r_done    <= 1'b1;
                            r_we      <= (rd_addr_in != 5'd0);
                            r_state   <= S_DONE;
                        end else begin
                            r_state   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_acc  <= w_acc_next;
                    r_quot <= w_quot_next;
                    r_rem  <= w_rem_next;
                    r_cnt  <= r_cnt + 5'd1;
                    if (r_cnt == CNT_LAST) begin
                        r_rd_data <= w_final;
                        r_done    <= 1'b1;
                        r_we      <= (r_rd_addr != 5'd0);
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign write_enable = r_we;
    assign rd_addr      = r_rd_addr;
    assign rd_data      = r_rd_data;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed results, latency and
// strobe behaviour, start-while-busy, reset mid-operation, rd = 0.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr_in;
    logic        busy;
    logic        done;
    logic        write_enable;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    state_t      dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .rd_addr_in   (rd_addr_in),
        .busy         (busy),
        .done         (done),
        .write_enable (write_enable),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver ----------------
    // Presents one op for a single accept edge, then counts cycles until done
    // (lat = 1 means done in the cycle right after the accept edge).
    task automatic do_op(input logic [2:0] t_op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         output int lat);
        @(negedge clk);
        op = t_op; rs1_data = a; rs2_data = b; rd_addr_in = rd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 3'd0; rs1_data = '0; rs2_data = '0; rd_addr_in = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", write_enable); end
        n_checks++; if (rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr); end
        n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        rst = 1'b0;
    endtask

    task automatic test_mul();
        int lat;
        do_op(OP_MUL, 32'd7, 32'hFFFFFFFD, 5'd5, lat);
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL mul_latency got=%0d exp=33", lat); end
        n_checks++; if (rd_data !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_data got=%h exp=ffffffeb", rd_data); end
        n_checks++; if (rd_addr !== 5'd5) begin n_fail++; $display("FAIL mul_rd_addr got=%0d exp=5", rd_addr); end
        n_checks++; if (write_enable !== 1'b1) begin n_fail++; $display("FAIL mul_we got=%b exp=1", write_enable); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mul_done_width got=%b exp=0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_after got=%b exp=0", busy); end
        n_checks++; if (rd_data !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_data_held got=%h exp=ffffffeb", rd_data); end
    endtask

    task automatic test_mulh();
        logic [2:0]  t_op [4] = '{OP_MULHU, OP_MULH, OP_MULHSU, OP_MULH};
        logic [31:0] t_a  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        logic [31:0] t_b  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002, 32'h00000003};
        logic [31:0] t_e  [4] = '{32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(t_op[i], t_a[i], t_b[i], 5'(8 + i), lat);
            n_checks++; if (rd_data !== t_e[i]) begin n_fail++; $display("FAIL mulh_data[%0d] got=%h exp=%h", i, rd_data, t_e[i]); end
            n_checks++; if (lat != 33) begin n_fail++; $display("FAIL mulh_latency[%0d] got=%0d exp=33", i, lat); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  t_op [6] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
        logic [31:0] t_a  [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd100, 32'd100};
        logic [31:0] t_b  [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9};
        logic [31:0] t_e  [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFF2, 32'd2};
        int lat;
        for (int i = 0; i < 6; i++) begin
            do_op(t_op[i], t_a[i], t_b[i], 5'(12 + i), lat);
            n_checks++; if (rd_data !== t_e[i]) begin n_fail++; $display("FAIL div_data[%0d] got=%h exp=%h", i, rd_data, t_e[i]); end
            n_checks++; if (lat != 33) begin n_fail++; $display("FAIL div_latency[%0d] got=%0d exp=33", i, lat); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  t_op [4] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM};
        logic [31:0] t_a  [4] = '{32'd100, 32'd100, 32'h80000000, 32'h80000000};
        logic [31:0] t_b  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] t_e  [4] = '{32'hFFFFFFFF, 32'd100, 32'h80000000, 32'h00000000};
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(t_op[i], t_a[i], t_b[i], 5'(20 + i), lat);
            n_checks++; if (rd_data !== t_e[i]) begin n_fail++; $display("FAIL special_data[%0d] got=%h exp=%h", i, rd_data, t_e[i]); end
            n_checks++; if (lat != 1) begin n_fail++; $display("FAIL special_latency[%0d] got=%0d exp=1", i, lat); end
            n_checks++; if (write_enable !== 1'b1) begin n_fail++; $display("FAIL special_we[%0d] got=%b exp=1", i, write_enable); end
            @(negedge clk);
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL special_done_width[%0d] got=%b exp=0", i, done); end
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        @(negedge clk);
        op = OP_MUL; rs1_data = 32'd7; rs2_data = 32'hFFFFFFFD; rd_addr_in = 5'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 10) begin
                // would finish at once (divide by zero) if it were wrongly taken
                op = OP_DIVU; rs1_data = 32'd100; rs2_data = 32'd0; rd_addr_in = 5'd9; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL ignore_latency got=%0d exp=33", lat); end
        n_checks++; if (rd_data !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL ignore_data got=%h exp=ffffffeb", rd_data); end
        n_checks++; if (rd_addr !== 5'd5) begin n_fail++; $display("FAIL ignore_rd_addr got=%0d exp=5", rd_addr); end
        do_op(OP_MUL, 32'd6, 32'd7, 5'd3, lat);
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL after_ignore_latency got=%0d exp=33", lat); end
        n_checks++; if (rd_data !== 32'd42) begin n_fail++; $display("FAIL after_ignore_data got=%h exp=0000002a", rd_data); end
        n_checks++; if (rd_addr !== 5'd3) begin n_fail++; $display("FAIL after_ignore_rd_addr got=%0d exp=3", rd_addr); end
    endtask

    task automatic test_back_to_back();
        // start held high: accept, DONE (start ignored), IDLE, accept, ...
        logic exp_done [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        @(negedge clk);
        op = OP_DIVU; rs1_data = 32'd100; rs2_data = 32'd0; rd_addr_in = 5'd1; start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++; if (done !== exp_done[i]) begin n_fail++; $display("FAIL b2b_done[%0d] got=%b exp=%b", i, done, exp_done[i]); end
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        op = OP_DIV; rs1_data = 32'd100; rs2_data = 32'd7; rd_addr_in = 5'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midcalc_busy got=%b exp=1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done got=%b exp=0", done); end
        n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL rstmid_rd_data got=%h exp=0", rd_data); end
        n_checks++; if (rd_addr !== 5'd0) begin n_fail++; $display("FAIL rstmid_rd_addr got=%0d exp=0", rd_addr); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (write_enable !== 1'b0 || done !== 1'b0) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rstmid_stray_strobe got=%0d exp=0", seen); end
    endtask

    task automatic test_rd_zero();
        int lat;
        do_op(OP_MUL, 32'd3, 32'd4, 5'd0, lat);
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL rd0_latency got=%0d exp=33", lat); end
        n_checks++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL rd0_we got=%b exp=0", write_enable); end
        n_checks++; if (rd_data !== 32'd12) begin n_fail++; $display("FAIL rd0_data got=%h exp=0000000c", rd_data); end
        @(negedge clk);
    endtask

    // ---------------- sequence ----------------
    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_rd_zero();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit downstream of `register_file`. It takes `rs1_data`/`rs2_data` plus the destination address, computes one of the eight M-extension operations over multiple cycles, and presents the result with a one-cycle write strobe. That strobe feeds the register file's `rd_addr`/`rd_data`/`write_enable` write port. The pipeline stalls on `busy`.

## Interface
- `XLEN`, 32: operand/result width; only 32 supported.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  request; accepted only in IDLE.
- `op`  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1_data`  in  32  operand A (dividend / multiplicand).
- `rs2_data`  in  32  operand B (divisor / multiplier).
- `rd_addr_in`  in  5  destination register captured on accept.
- `busy`  out  1  high in CALC and DONE.
- `done`  out  1  one-cycle pulse, high only in DONE.
- `write_enable`  out  1  equals `done`, suppressed when captured rd = 0.
- `rd_addr`  out  5  captured destination; held until next accept.
- `rd_data`  out  32  result; valid when `done`, held until next accept.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE to CALC: `start`=1 at an edge.
  - Latches `op`, `rd_addr_in`, absolute values of operands, and result sign flags.
  - Clears the iteration counter.
- IDLE to DONE directly (special cases; `rd_data` loaded on the same edge):
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give `rs1_data`.
  - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC: one radix-2 step per cycle for 32 cycles; 5-bit counter; goes to DONE when the counter reads 31.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, 32-bit quotient plus 33-bit partial remainder.
- CALC to DONE: sign correction applied and `rd_data` loaded on the same edge.
  - MUL: low 32 bits.
  - MULH/MULHSU/MULHU: high 32 bits.
  - Signedness: MULH both signed; MULHSU rs1 signed, rs2 unsigned.
  - Quotient is negated if operand signs differ (signed ops).
  - Remainder takes the dividend's sign.
- DONE to IDLE: unconditional after one cycle.
- `start` while `busy` is ignored. No queuing; upstream holds the instruction until IDLE.
- Reset (any state, including mid-CALC):
  - State returns to IDLE; counter cleared.
  - `busy`=0, `done`=0, `write_enable`=0, `rd_addr`=0, `rd_data`=0.
  - In-flight operation discarded.

## Timing
- Accept edge E0: `busy` goes high after E0.
- Normal operation: `done`/`write_enable` high during the cycle after edge E0+32, so the result is written at edge E0+33. Throughput is one op per 34 cycles (IDLE cycle before next accept).
- Special case: `done` high in the cycle after E0; written at edge E0+1.
- `start` sampled in the DONE cycle is ignored (state is not IDLE).
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- `muldiv_pkg`:
  - `op` encodings as localparams (OP_MUL … OP_REMU).
  - State encoding (S_IDLE, S_CALC, S_DONE).
  - `CALC_CYCLES` = 32.
- One sub-module, `muldiv_sign_fix`: combinational abs-value/negate helper, instantiated for operand conditioning and result correction.
- Datapath and FSM live in `muldiv_unit`.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), rd = 5:
  - `rd_data` = 0xFFFFFFEB, `rd_addr` = 5.
  - `done` exactly 33 cycles after accept, width 1.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFE; MULH of the same operands gives 0x00000000; MULHSU 0xFFFFFFFF × 2 gives 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 gives 0xFFFFFFFD; REM gives 0xFFFFFFFF; DIVU 100 / 7 gives 14; REMU gives 2.
- Special cases, each with `done` 1 cycle after accept:
  - DIVU 100 / 0 gives 0xFFFFFFFF.
  - REMU 100 / 0 gives 100.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000.
  - REM of the same operands gives 0.
- Second `start` with different operands at cycle 10 of a MUL: ignored; the first result is unchanged; a new `start` after `done` is accepted normally.
- Reset at cycle 15 of a DIV:
  - Next cycle: `busy` = 0, `done` = 0, `rd_data` = 0, `rd_addr` = 0.
  - No `write_enable` pulse ever appears for the aborted op.
  - An op with rd = 0 produces `done` = 1 but `write_enable` = 0.
